// File: rtl/cipher_host_link_if.sv
// Local command/response port of cipher_host_link.
// The slave modport is the link itself; the master modport is the local command source and sink.
interface cipher_host_link_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_byte;
  logic       cmd_is_key;
  logic       cmd_reset_hash;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_byte;

  modport master (
    output cmd_valid,
    output cmd_byte,
    output cmd_is_key,
    output cmd_reset_hash,
    output rsp_ready,
    input  cmd_ready,
    input  rsp_valid,
    input  rsp_byte
  );

  modport slave (
    input  cmd_valid,
    input  cmd_byte,
    input  cmd_is_key,
    input  cmd_reset_hash,
    input  rsp_ready,
    output cmd_ready,
    output rsp_valid,
    output rsp_byte
  );
endinterface

// File: rtl/cipher_host_link.sv
// Host-side initiator for the stream cipher's four-phase byte interface.
// Runs one command at a time through the input handshake and, for data bytes, the output handshake.
module cipher_host_link #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic              clk,
  input  logic              rst,
  cipher_host_link_if.slave host,
  output logic [7:0]        chip_input_byte,
  output logic              chip_is_key,
  output logic              chip_reset_hash,
  output logic              chip_input_request,
  input  logic              chip_input_acknowledged,
  input  logic              chip_output_byte_is_ready,
  output logic              chip_output_acknowledge,
  input  logic [7:0]        chip_output_byte,
  output logic              busy,
  output logic              timeout_err,
  input  logic              err_clear
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {StIdle, StReq, StRel, StWaitRdy, StOack, StRsp} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      ack_sync_q, rdy_sync_q;
  logic            ack_s, rdy_s;
  logic            accept, waiting, timeout, is_data;
  logic [7:0]      in_byte_q, rsp_byte_q;
  logic            is_key_q, reset_hash_q;
  logic            req_q, oack_q, rsp_valid_q, err_q;

  assign ack_s   = ack_sync_q[1];
  assign rdy_s   = rdy_sync_q[1];
  assign accept  = host.cmd_valid && host.cmd_ready;
  // The latched flags describe the transaction in flight until the next accept.
  assign is_data = !is_key_q && !reset_hash_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timeout = 1'b0;
    case (state_q)
      StIdle:    if (accept)           state_d = StReq;
      StReq:     if (ack_s)            state_d = StRel;
      StRel:     if (!ack_s)           state_d = is_data ? StWaitRdy : StIdle;
      StWaitRdy: if (rdy_s)            state_d = StOack;
      StOack:    if (!rdy_s)           state_d = StRsp;
      StRsp:     if (host.rsp_ready)   state_d = StIdle;
      default:                         state_d = StIdle;
    endcase
    waiting = state_q inside {StReq, StRel, StWaitRdy, StOack};
    // A handshake progressing in the same cycle wins over the abort.
    if (waiting && state_d == state_q && cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
      timeout = 1'b1;
      state_d = StIdle;
    end
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (waiting) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      ack_sync_q   <= '0;
      rdy_sync_q   <= '0;
      in_byte_q    <= '0;
      is_key_q     <= 1'b0;
      reset_hash_q <= 1'b0;
      rsp_byte_q   <= '0;
      req_q        <= 1'b0;
      oack_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ack_sync_q <= {ack_sync_q[0], chip_input_acknowledged};
      rdy_sync_q <= {rdy_sync_q[0], chip_output_byte_is_ready};
      if (accept) begin
        in_byte_q    <= host.cmd_byte;
        is_key_q     <= host.cmd_is_key;
        reset_hash_q <= host.cmd_reset_hash;
      end
      // The cipher holds its output byte stable until acknowledged, so no synchroniser here.
      if (state_q == StWaitRdy && rdy_s) begin
        rsp_byte_q <= chip_output_byte;
      end
      req_q       <= (state_d == StReq);
      oack_q      <= (state_d == StOack);
      rsp_valid_q <= (state_d == StRsp);
      if (timeout) begin
        err_q <= 1'b1;
      end else if (err_clear) begin
        err_q <= 1'b0;
      end
    end
  end

  assign host.cmd_ready          = (state_q == StIdle) && !rst;
  assign host.rsp_valid          = rsp_valid_q;
  assign host.rsp_byte           = rsp_byte_q;
  assign chip_input_byte         = in_byte_q;
  assign chip_is_key             = is_key_q;
  assign chip_reset_hash         = reset_hash_q;
  assign chip_input_request      = req_q;
  assign chip_output_acknowledge = oack_q;
  assign busy                    = (state_q != StIdle);
  assign timeout_err             = err_q;

endmodule

// File: tb/tb_cipher_host_link.sv
// Directed bench for cipher_host_link: key, data, hash reset, timeout, reset mid-transfer
// and back-to-back data against a free-running responder.
module tb_cipher_host_link;
  localparam int unsigned Tmo = 16;
  localparam int SigReq = 0, SigOack = 1, SigRspValid = 2, SigBusy = 3;

  logic       clk, rst, err_clear;
  logic [7:0] chip_input_byte, chip_output_byte_pin;
  logic       chip_is_key, chip_reset_hash, chip_input_request, chip_output_acknowledge;
  logic       busy, timeout_err, ack_pin, rdy_pin;
  logic       man_ack, man_rdy, auto_en, auto_ack, auto_rdy, mon6, prev_req;
  logic [7:0] man_obyte, auto_obyte;
  int         checks = 0, errors = 0;
  int         oack_cnt = 0, rsp_hi_cnt = 0, req_rises = 0, overlap = 0, idle_cnt = 0;
  logic [7:0] rsp_q[$];
  int         gaps[$];

  cipher_host_link_if host_bus ();

  assign ack_pin              = auto_en ? auto_ack : man_ack;
  assign rdy_pin              = auto_en ? auto_rdy : man_rdy;
  assign chip_output_byte_pin = auto_en ? auto_obyte : man_obyte;

  cipher_host_link #(.TIMEOUT_CYCLES(Tmo)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .host                      (host_bus),
    .chip_input_byte           (chip_input_byte),
    .chip_is_key               (chip_is_key),
    .chip_reset_hash           (chip_reset_hash),
    .chip_input_request        (chip_input_request),
    .chip_input_acknowledged   (ack_pin),
    .chip_output_byte_is_ready (rdy_pin),
    .chip_output_acknowledge   (chip_output_acknowledge),
    .chip_output_byte          (chip_output_byte_pin),
    .busy                      (busy),
    .timeout_err               (timeout_err),
    .err_clear                 (err_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic pick(input int which);
    case (which)
      SigReq:      return chip_input_request;
      SigOack:     return chip_output_acknowledge;
      SigRspValid: return host_bus.rsp_valid;
      default:     return busy;
    endcase
  endfunction

  task automatic wait_for(input int which, input logic lvl, input string tag);
    int n = 0;
    while (pick(which) !== lvl && n < 40) begin
      tick();
      n++;
    end
    check_eq(tag, {31'd0, pick(which)}, {31'd0, lvl});
  endtask

  task automatic send_cmd(input logic [7:0] b, input logic k, input logic h, input string tag);
    int n = 0;
    while (!host_bus.cmd_ready && n < 40) begin
      tick();
      n++;
    end
    check_eq(tag, {31'd0, host_bus.cmd_ready}, 32'd1);
    host_bus.cmd_byte       = b;
    host_bus.cmd_is_key     = k;
    host_bus.cmd_reset_hash = h;
    host_bus.cmd_valid      = 1'b1;
    tick();
    host_bus.cmd_valid = 1'b0;
  endtask

  // Ack two cycles after req is seen, drop ack two cycles after req falls.
  task automatic input_hs(input string tag);
    tick();
    tick();
    man_ack = 1'b1;
    wait_for(SigReq, 1'b0, tag);
    tick();
    tick();
    man_ack = 1'b0;
  endtask

  // Counters on the opposite edge; test 6 bookkeeping only while mon6 is set.
  always @(negedge clk) begin
    if (chip_output_acknowledge) oack_cnt <= oack_cnt + 1;
    if (host_bus.rsp_valid) rsp_hi_cnt <= rsp_hi_cnt + 1;
    if (mon6) begin
      if (host_bus.rsp_valid && host_bus.rsp_ready) rsp_q.push_back(host_bus.rsp_byte);
      if (chip_input_request && !prev_req) begin
        if (req_rises != rsp_q.size()) overlap <= overlap + 1;
        req_rises <= req_rises + 1;
      end
      if (!busy) begin
        idle_cnt <= idle_cnt + 1;
      end else begin
        if (idle_cnt > 0 && rsp_q.size() > 0) gaps.push_back(idle_cnt);
        idle_cnt <= 0;
      end
    end
    prev_req <= chip_input_request;
  end

  // Cipher model for back-to-back traffic: answers each data byte with byte ^ 0xFF.
  initial begin : responder
    int         rs;
    logic [7:0] lat;
    rs = 0;
    lat = 8'h00;
    auto_ack = 1'b0;
    auto_rdy = 1'b0;
    auto_obyte = 8'h00;
    forever begin
      @(negedge clk);
      if (auto_en) begin
        case (rs)
          0: if (chip_input_request) begin
               lat = chip_input_byte;
               auto_ack = 1'b1;
               rs = 1;
             end
          1: if (!chip_input_request) begin
               auto_ack = 1'b0;
               rs = 2;
             end
          2: begin
               auto_obyte = lat ^ 8'hFF;
               auto_rdy = 1'b1;
               rs = 3;
             end
          default: if (chip_output_acknowledge) begin
               auto_rdy = 1'b0;
               rs = 0;
             end
        endcase
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int base_o, base_r, hi, stable, n, guard;
    logic acc;
    rst = 1'b1;
    err_clear = 1'b0;
    man_ack = 1'b0;
    man_rdy = 1'b0;
    man_obyte = 8'h00;
    auto_en = 1'b0;
    mon6 = 1'b0;
    host_bus.cmd_valid = 1'b0;
    host_bus.cmd_byte = 8'h00;
    host_bus.cmd_is_key = 1'b0;
    host_bus.cmd_reset_hash = 1'b0;
    host_bus.rsp_ready = 1'b0;
    tick();
    tick();
    check_eq("reset_outputs", {chip_input_request, chip_output_acknowledge, host_bus.rsp_valid,
             host_bus.rsp_byte, chip_input_byte, chip_is_key, chip_reset_hash, busy,
             timeout_err, host_bus.cmd_ready}, 32'd0);
    rst = 1'b0;
    tick();
    check_eq("reset_cmd_ready", {31'd0, host_bus.cmd_ready}, 32'd1);

    // 1: key byte
    base_o = oack_cnt;
    base_r = rsp_hi_cnt;
    send_cmd(8'hA5, 1'b1, 1'b0, "key_accept");
    check_eq("key_byte", {24'd0, chip_input_byte}, 32'hA5);
    check_eq("key_flag", {31'd0, chip_is_key}, 32'd1);
    check_eq("key_req", {31'd0, chip_input_request}, 32'd1);
    check_eq("key_busy_ready", {30'd0, busy, host_bus.cmd_ready}, 32'b10);
    tick();
    tick();
    man_ack = 1'b1;
    tick();
    tick();
    check_eq("key_req_e1", {31'd0, chip_input_request}, 32'd1);
    tick();
    check_eq("key_req_e2", {31'd0, chip_input_request}, 32'd0);
    tick();
    tick();
    man_ack = 1'b0;
    wait_for(SigBusy, 1'b0, "key_idle");
    check_eq("key_no_oack", oack_cnt - base_o, 32'd0);
    check_eq("key_no_rsp", rsp_hi_cnt - base_r, 32'd0);
    check_eq("key_byte_held", {24'd0, chip_input_byte}, 32'hA5);

    // 2: data byte with backpressure
    send_cmd(8'h3C, 1'b0, 1'b0, "data_accept");
    input_hs("data_req_fall");
    repeat (4) tick();
    man_obyte = 8'h96;
    man_rdy = 1'b1;
    tick();
    tick();
    check_eq("data_oack_r1", {31'd0, chip_output_acknowledge}, 32'd0);
    tick();
    check_eq("data_oack_r2", {31'd0, chip_output_acknowledge}, 32'd1);
    tick();
    tick();
    man_rdy = 1'b0;
    man_obyte = 8'h55;
    tick();
    tick();
    check_eq("data_oack_g1", {30'd0, chip_output_acknowledge, host_bus.rsp_valid}, 32'b10);
    tick();
    check_eq("data_oack_g2", {30'd0, chip_output_acknowledge, host_bus.rsp_valid}, 32'b01);
    stable = 0;
    for (int i = 0; i < 5; i++) begin
      if (host_bus.rsp_valid && host_bus.rsp_byte == 8'h96) stable++;
      tick();
    end
    check_eq("data_rsp_hold", stable, 32'd5);
    check_eq("data_rsp_byte", {23'd0, host_bus.rsp_valid, host_bus.rsp_byte}, 32'h196);
    host_bus.rsp_ready = 1'b1;
    tick();
    host_bus.rsp_ready = 1'b0;
    check_eq("data_done", {29'd0, host_bus.rsp_valid, busy, host_bus.cmd_ready}, 32'b001);

    // 3: hash reset
    base_o = oack_cnt;
    base_r = rsp_hi_cnt;
    send_cmd(8'h00, 1'b0, 1'b1, "hash_accept");
    check_eq("hash_flags", {29'd0, chip_reset_hash, chip_is_key, chip_input_request}, 32'b101);
    input_hs("hash_req_fall");
    wait_for(SigBusy, 1'b0, "hash_idle");
    check_eq("hash_no_oack", oack_cnt - base_o, 32'd0);
    check_eq("hash_no_rsp", rsp_hi_cnt - base_r, 32'd0);

    // 4: timeout with no ack
    send_cmd(8'h77, 1'b0, 1'b0, "tmo_accept");
    hi = 0;
    for (int i = 1; i < Tmo; i++) begin
      tick();
      if (chip_input_request) hi++;
    end
    check_eq("tmo_req_hold", hi, Tmo - 1);
    tick();
    check_eq("tmo_abort", {28'd0, chip_input_request, timeout_err, host_bus.cmd_ready, busy},
             32'b0110);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check_eq("tmo_clear", {31'd0, timeout_err}, 32'd0);
    send_cmd(8'h78, 1'b0, 1'b0, "tmo2_accept");
    repeat (Tmo - 1) tick();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check_eq("tmo_set_wins", {30'd0, timeout_err, chip_input_request}, 32'b10);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;

    // 5: reset while in OACK, then a normal transfer
    send_cmd(8'h40, 1'b0, 1'b0, "rst_accept");
    input_hs("rst_req_fall");
    repeat (4) tick();
    man_obyte = 8'hEE;
    man_rdy = 1'b1;
    wait_for(SigOack, 1'b1, "rst_reach_oack");
    rst = 1'b1;
    man_rdy = 1'b0;
    tick();
    check_eq("rst_mid_outputs", {chip_input_request, chip_output_acknowledge, host_bus.rsp_valid,
             host_bus.rsp_byte, chip_input_byte, chip_is_key, chip_reset_hash, busy,
             timeout_err, host_bus.cmd_ready}, 32'd0);
    rst = 1'b0;
    tick();
    send_cmd(8'h11, 1'b0, 1'b0, "post_rst_accept");
    input_hs("post_rst_req_fall");
    repeat (4) tick();
    man_obyte = 8'h22;
    man_rdy = 1'b1;
    wait_for(SigOack, 1'b1, "post_rst_oack");
    man_rdy = 1'b0;
    wait_for(SigRspValid, 1'b1, "post_rst_rsp");
    check_eq("post_rst_byte", {24'd0, host_bus.rsp_byte}, 32'h22);
    host_bus.rsp_ready = 1'b1;
    tick();
    host_bus.rsp_ready = 1'b0;
    wait_for(SigBusy, 1'b0, "post_rst_idle");

    // 6: back-to-back data with cmd_valid held
    auto_en = 1'b1;
    mon6 = 1'b1;
    host_bus.rsp_ready = 1'b1;
    host_bus.cmd_is_key = 1'b0;
    host_bus.cmd_reset_hash = 1'b0;
    host_bus.cmd_byte = 8'h01;
    host_bus.cmd_valid = 1'b1;
    n = 0;
    guard = 0;
    while (n < 4 && guard < 400) begin
      acc = host_bus.cmd_ready;
      tick();
      guard++;
      if (acc) begin
        n++;
        host_bus.cmd_byte = 8'(n + 1);
        if (n == 4) host_bus.cmd_valid = 1'b0;
      end
    end
    check_eq("b2b_accepts", n, 32'd4);
    guard = 0;
    while (rsp_q.size() < 4 && guard < 400) begin
      tick();
      guard++;
    end
    repeat (3) tick();
    check_eq("b2b_rsp_count", rsp_q.size(), 32'd4);
    for (int i = 0; i < 4 && i < rsp_q.size(); i++) begin
      check_eq($sformatf("b2b_rsp%0d", i), {24'd0, rsp_q[i]}, {24'd0, 8'(8'hFE - i)});
    end
    check_eq("b2b_req_count", req_rises, 32'd4);
    check_eq("b2b_overlap", overlap, 32'd0);
    check_eq("b2b_gap_count", gaps.size(), 32'd3);
    for (int i = 0; i < gaps.size(); i++) begin
      check_eq($sformatf("b2b_gap%0d", i), gaps[i], 32'd1);
    end
    mon6 = 1'b0;
    auto_en = 1'b0;
    host_bus.rsp_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cipher_host_link.md
# cipher_host_link

- Host-side initiator for the stream cipher's four-phase byte interface.
- Accepts local commands (key byte, data byte, or hash reset) on a valid/ready port and drives the cipher's request pins.
- Completes the input handshake and, for data bytes, the output handshake, then returns the encrypted byte on a valid/ready response port.
- Sits on the FPGA/test-harness side of the chip pins and drives the cipher's input handshake and output acknowledge.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 1023: maximum cycles spent in any waiting state before abort. Legal range is ≥ 4.

Ports:
- clk  in  1  single clock; all logic is on its rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  local command present
- cmd_ready  out  1  high only in IDLE while rst is low
- cmd_byte  in  8  byte to send
- cmd_is_key  in  1  byte is a key byte
- cmd_reset_hash  in  1  command is a hash reset
- rsp_valid  out  1  encrypted byte available
- rsp_ready  in  1  local sink accepts rsp_byte
- rsp_byte  out  8  encrypted byte
- chip_input_byte  out  8  byte driven to the cipher
- chip_is_key  out  1  key flag driven to the cipher
- chip_reset_hash  out  1  hash-reset flag driven to the cipher
- chip_input_request  out  1  four-phase request
- chip_input_acknowledged  in  1  cipher input acknowledge; asynchronous to clk
- chip_output_byte_is_ready  in  1  cipher output ready; asynchronous to clk
- chip_output_acknowledge  out  1  host acknowledge of the output byte
- chip_output_byte  in  8  encrypted byte from the cipher
- busy  out  1  state is not IDLE
- timeout_err  out  1  sticky abort flag
- err_clear  in  1  clears timeout_err

## Operation
- **Synchronisers:** chip_input_acknowledged and chip_output_byte_is_ready each pass through 2-flop synchronisers, giving ack_s and rdy_s. chip_output_byte is not synchronised; it is sampled only while rdy_s=1, because the cipher holds it stable until acknowledged.
- **Output timing:** all chip-side and rsp outputs are registered, Moore-style, from the state.
- **Command classes:**
  - data: cmd_is_key=0 and cmd_reset_hash=0.
  - control: either flag set; no output is expected.
- **States:**
  - IDLE: on cmd_valid&&cmd_ready, latch cmd_byte, cmd_is_key and cmd_reset_hash into the chip_* outputs, then go to REQ.
  - REQ: chip_input_request=1. When ack_s=1, go to REL.
  - REL: chip_input_request=0. When ack_s=0, go to WAIT_RDY for data or IDLE for control.
  - WAIT_RDY: when rdy_s=1, capture chip_output_byte into rsp_byte and go to OACK.
  - OACK: chip_output_acknowledge=1. When rdy_s=0, go to RSP.
  - RSP: chip_output_acknowledge=0 and rsp_valid=1. On rsp_ready, go to IDLE.
- **Outstanding commands:** only one transaction is outstanding at a time. chip_input_byte, chip_is_key and chip_reset_hash hold their values until the next accept.
- **Timeout counter:**
  - Clears on every state change.
  - Increments in REQ, REL, WAIT_RDY and OACK.
  - When it reaches TIMEOUT_CYCLES, go to IDLE with chip_input_request=0 and chip_output_acknowledge=0, set timeout_err, and produce no response.
  - RSP never times out; local backpressure is unbounded.
- **timeout_err:** set has priority over err_clear in the same cycle. It does not block new commands.
- **rdy_s already high on entering WAIT_RDY:** the byte is captured immediately (ready stays high until acknowledged).

## Timing
- **Reset:** with rst high at an edge, the next state is IDLE. All outputs become 0, including rsp_byte, chip_input_byte, timeout_err and busy. cmd_ready is 0 while rst=1, and both synchronisers clear. Reset mid-transaction abandons it without any further pin toggles.
- **Accept:** for an accept at edge T, chip_input_request and the chip data outputs are valid after T. busy=1 and cmd_ready=0 from T.
- **Input acknowledge:** if chip_input_acknowledged is first sampled high at edge E, chip_input_request falls at edge E+2. Ack falling, first sampled low at edge F, produces the state change at F+2.
- **Output handshake:** the ready rise sampled at edge R means the byte is captured at R+2 and chip_output_acknowledge rises at R+2. The ready fall sampled at edge G means acknowledge falls and rsp_valid rises at G+2.
- **Response:** rsp_valid and rsp_byte are stable until the rsp_valid&&rsp_ready edge. cmd_ready=1 in the cycle after that edge, so back-to-back commands have one IDLE cycle between them.

## Test plan
1. **Key byte:** cmd 0xA5, is_key=1; responder acks 2 cycles after req and drops ack 2 cycles after req falls. Require: chip_input_byte=0xA5 and chip_is_key=1 during req, req falls at E+2, chip_output_acknowledge never rises, rsp_valid never rises, busy returns to 0.
2. **Data byte:** cmd 0x3C; responder returns 0x96; rsp_ready held 0 for 5 cycles. Require: output_acknowledge rises after ready and falls after ready drops, rsp_byte=0x96 with rsp_valid held all 5 cycles, then IDLE.
3. **Hash reset:** cmd_reset_hash=1. Require: chip_reset_hash=1 while req is high, then a control-path return to IDLE with no rsp.
4. **Timeout:** TIMEOUT_CYCLES=16 and the responder never acks. Require: req drops after 16 cycles in REQ, timeout_err=1 and cmd_ready=1. A following err_clear pulse gives timeout_err=0. err_clear coincident with a new timeout leaves the flag at 1.
5. **Reset in OACK:** assert rst while in OACK. Require: all outputs 0 the next cycle; a subsequent data cmd 0x11 with response 0x22 completes normally.
6. **Back-to-back data:** cmd_valid held with bytes 0x01–0x04; responder maps b to b^0xFF. Require: rsp order 0xFE, 0xFD, 0xFC, 0xFB, never more than one request outstanding, and exactly one IDLE cycle between transactions.
